alu_seq: RTL

- Parametrised successor to the team's 8-bit registered ALU.
- Operand width is generic, with a 2*WIDTH-bit result and a one-cycle result-valid strobe.
- Division is a multi-cycle iterative restoring divider with a BUSY handshake, a divide-by-zero error flag, and a remainder output.
- Sits between the register-file/command decoder and the UART TX result path, the same place the 8-bit ALU occupies today.

---
 rtl/alu_seq_if.sv | 37 +++
 rtl/alu_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Request/result bundle for alu_seq: operands, opcode and enable in; result, strobe and status out.
// ZERO and CARRY are present only when ALU_FLAGS_EN is defined.
interface alu_seq_if #(
  parameter int WIDTH = 8,
  parameter int OP_W  = 4
);
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [OP_W-1:0]    ALU_FUN;
  logic               ALU_EN;
  logic [2*WIDTH-1:0] ALU_OUT;
  logic               OUT_valid;
  logic               BUSY;
  logic               DIV_ERR;
`ifdef ALU_FLAGS_EN
  logic               ZERO;
  logic               CARRY;

  modport master (
    output A, B, ALU_FUN, ALU_EN,
    input  ALU_OUT, OUT_valid, BUSY, DIV_ERR, ZERO, CARRY
  );
  modport slave (
    input  A, B, ALU_FUN, ALU_EN,
    output ALU_OUT, OUT_valid, BUSY, DIV_ERR, ZERO, CARRY
  );
`else
  modport master (
    output A, B, ALU_FUN, ALU_EN,
    input  ALU_OUT, OUT_valid, BUSY, DIV_ERR
  );
  modport slave (
    input  A, B, ALU_FUN, ALU_EN,
    output ALU_OUT, OUT_valid, BUSY, DIV_ERR
  );
`endif
endinterface

// File: rtl/alu_seq.sv
// Parametrised registered ALU with a multi-cycle restoring divider (one quotient bit per cycle).
// Optional ZERO/CARRY flag outputs are enabled with the ALU_FLAGS_EN macro.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int OP_W  = 4
) (
  input logic       CLK,
  input logic       RST,
  alu_seq_if.slave  bus
);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_NAND = OP_W'(6);
  localparam logic [OP_W-1:0] OP_NOR  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_XNOR = OP_W'(9);
  localparam logic [OP_W-1:0] OP_EQ   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_GT   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_LT   = OP_W'(12);
  localparam logic [OP_W-1:0] OP_SHR  = OP_W'(13);
  localparam logic [OP_W-1:0] OP_SHL  = OP_W'(14);

  localparam int              LAST_ITER_I = WIDTH - 1;
  localparam logic [WIDTH-1:0] LAST_ITER  = LAST_ITER_I[WIDTH-1:0];

  typedef enum logic {S_IDLE, S_DIV} state_t;

  state_t             state_reg;
  logic               busy_reg;
  logic [2*WIDTH-1:0] out_reg;
  logic               valid_reg;
  logic               err_reg;
  logic [WIDTH-1:0]   div_reg;
  logic [WIDTH-1:0]   quo_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic [WIDTH-1:0]   cnt_reg;

  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [2*WIDTH-1:0] op_result;
  logic               op_valid;
  logic               op_err;
  logic               div_start;
  logic [WIDTH:0]     trial_w;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;

  // Single-cycle datapath, evaluated directly from the bus on the accept edge
  always_comb begin
    sum_w     = {1'b0, bus.A} + {1'b0, bus.B};
    diff_w    = {1'b0, bus.A} - {1'b0, bus.B};
    op_result = '0;
    op_valid  = 1'b1;
    op_err    = 1'b0;
    div_start = 1'b0;
    case (bus.ALU_FUN)
      OP_ADD:  op_result[WIDTH:0] = sum_w;
      OP_SUB:  op_result[WIDTH:0] = diff_w;
      OP_MUL:  op_result = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
      OP_DIV: begin
        if (bus.B == '0) begin
          op_result = {bus.A, {WIDTH{1'b1}}};
          op_err    = 1'b1;
        end else begin
          op_valid  = 1'b0;
          div_start = 1'b1;
        end
      end
      OP_AND:  op_result[WIDTH-1:0] = bus.A & bus.B;
      OP_OR:   op_result[WIDTH-1:0] = bus.A | bus.B;
      OP_NAND: op_result[WIDTH-1:0] = ~(bus.A & bus.B);
      OP_NOR:  op_result[WIDTH-1:0] = ~(bus.A | bus.B);
      OP_XOR:  op_result[WIDTH-1:0] = bus.A ^ bus.B;
      OP_XNOR: op_result[WIDTH-1:0] = ~(bus.A ^ bus.B);
      OP_EQ:   if (bus.A == bus.B) op_result[1:0] = 2'd1;
      OP_GT:   if (bus.A > bus.B)  op_result[1:0] = 2'd2;
      OP_LT:   if (bus.A < bus.B)  op_result[1:0] = 2'd3;
      OP_SHR:  op_result[WIDTH-1:0] = bus.A >> 1;
      OP_SHL:  op_result[WIDTH:0] = {bus.A, 1'b0};
      default: op_valid = 1'b0;
    endcase
  end

  // Restoring step: the partial remainder is always below the divisor, so WIDTH bits suffice
  always_comb begin
    trial_w = {rem_reg, quo_reg[WIDTH-1]};
    if (trial_w >= {1'b0, div_reg}) begin
      rem_next = trial_w[WIDTH-1:0] - div_reg;
      quo_next = {quo_reg[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = trial_w[WIDTH-1:0];
      quo_next = {quo_reg[WIDTH-2:0], 1'b0};
    end
  end

`ifdef ALU_FLAGS_EN
  logic zero_reg;
  logic carry_reg;
  logic op_carry;

  always_comb begin
    op_carry = 1'b0;
    if (bus.ALU_FUN == OP_ADD)      op_carry = sum_w[WIDTH];
    else if (bus.ALU_FUN == OP_SUB) op_carry = diff_w[WIDTH];
  end

  assign bus.ZERO  = zero_reg;
  assign bus.CARRY = carry_reg;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= S_IDLE;
      busy_reg  <= 1'b0;
      out_reg   <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      div_reg   <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      cnt_reg   <= '0;
`ifdef ALU_FLAGS_EN
      zero_reg  <= 1'b0;
      carry_reg <= 1'b0;
`endif
    end else begin
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
`ifdef ALU_FLAGS_EN
      zero_reg  <= 1'b0;
      carry_reg <= 1'b0;
`endif
      case (state_reg)
        S_IDLE: begin
          if (bus.ALU_EN) begin
            if (div_start) begin
              state_reg <= S_DIV;
              busy_reg  <= 1'b1;
              div_reg   <= bus.B;
              quo_reg   <= bus.A;
              rem_reg   <= '0;
              cnt_reg   <= '0;
            end else if (op_valid) begin
              out_reg   <= op_result;
              valid_reg <= 1'b1;
              err_reg   <= op_err;
`ifdef ALU_FLAGS_EN
              zero_reg  <= (op_result == '0);
              carry_reg <= op_carry;
`endif
            end
          end
        end
        S_DIV: begin
          quo_reg <= quo_next;
          rem_reg <= rem_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_ITER) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
            out_reg   <= {rem_next, quo_next};
            valid_reg <= 1'b1;
`ifdef ALU_FLAGS_EN
            zero_reg  <= ({rem_next, quo_next} == '0);
`endif
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.ALU_OUT   = out_reg;
  assign bus.OUT_valid = valid_reg;
  assign bus.BUSY      = busy_reg;
  assign bus.DIV_ERR   = err_reg;

endmodule
